// File: rtl/loader_sdram_writer.sv
// Loader-to-SDRAM write buffer: queues loader byte writes and replays them as
// 2-cycle port-B strobes on clkref. Optional sum: LOADER_SDRAM_WRITER_CHECKSUM_EN.
module loader_sdram_writer #(
    parameter int DEPTH  = 16,
    parameter int ADDR_W = 22
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              clear,
    input  logic [ADDR_W-1:0] in_addr,
    input  logic [7:0]        in_data,
    input  logic              in_write,
    input  logic              clkref,
    input  logic              sdram_busy,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [7:0]        mem_data,
    output logic              mem_we,
    output logic              full,
    output logic              idle,
    output logic              overflow,
    output logic [ADDR_W-1:0] bytes_done,
    output logic [15:0]       checksum
);
    localparam int PW = $clog2(DEPTH);
    localparam logic [PW:0] DEPTH_C = (PW+1)'(DEPTH);

    typedef struct packed {
        logic [ADDR_W-1:0] addr;
        logic [7:0]        data;
    } entry_t;

    typedef enum logic [1:0] {IDLE, WE0, WE1} state_t;

    entry_t        fifo [DEPTH];
    entry_t        head;
    logic [PW-1:0] wr_ptr, rd_ptr;
    logic [PW:0]   count;
    state_t        state;
    logic          push, pop;

    assign head = fifo[rd_ptr];
    assign full = (count == DEPTH_C);
    assign idle = (count == '0) && (state == IDLE);
    // full is taken from the pre-pop count, so a push against a full FIFO drops
    // even when the same edge frees a slot.
    assign push = in_write && !full;
    assign pop  = (state == IDLE) && (count != '0) && !sdram_busy && clkref;

    always_ff @(posedge clk) begin
        if (push && !clear)
            fifo[wr_ptr] <= entry_t'{addr: in_addr, data: in_data};
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            count      <= '0;
            state      <= IDLE;
            mem_addr   <= '0;
            mem_data   <= '0;
            mem_we     <= 1'b0;
            overflow   <= 1'b0;
            bytes_done <= '0;
        end else if (clear) begin
            // an aborted strobe is never counted
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            count      <= '0;
            state      <= IDLE;
            mem_we     <= 1'b0;
            overflow   <= 1'b0;
            bytes_done <= '0;
        end else begin
            if (push)
                wr_ptr <= wr_ptr + 1'b1;
            if (pop)
                rd_ptr <= rd_ptr + 1'b1;
            if (in_write && full)
                overflow <= 1'b1;
            case ({push, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: ;
            endcase
            case (state)
                IDLE: if (pop) begin
                    state    <= WE0;
                    mem_we   <= 1'b1;
                    mem_addr <= head.addr;
                    mem_data <= head.data;
                end
                WE0: state <= WE1;
                WE1: begin
                    state      <= IDLE;
                    mem_we     <= 1'b0;
                    bytes_done <= bytes_done + 1'b1;
                end
                default: begin
                    state  <= IDLE;
                    mem_we <= 1'b0;
                end
            endcase
        end
    end

`ifdef LOADER_SDRAM_WRITER_CHECKSUM_EN
    always_ff @(posedge clk or posedge reset) begin
        if (reset)
            checksum <= '0;
        else if (clear)
            checksum <= '0;
        else if (pop)
            checksum <= checksum + {8'h00, head.data};
    end
`else
    assign checksum = 16'h0000;
`endif

endmodule

// File: tb/tb_loader_sdram_writer.sv
// Directed bench for loader_sdram_writer: strobe shape, ordering, backpressure,
// overflow, clear abort and asynchronous reset.
module tb_loader_sdram_writer;
    logic        clk = 1'b0, reset = 1'b1, clear = 1'b0;
    logic [21:0] in_addr = '0;
    logic [7:0]  in_data = '0;
    logic        in_write = 1'b0, clkref = 1'b0, sdram_busy = 1'b0;
    logic [21:0] mem_addr, bytes_done;
    logic [7:0]  mem_data;
    logic        mem_we, full, idle, overflow;
    logic [15:0] checksum;

    int checks = 0, errors = 0;

    loader_sdram_writer #(.DEPTH(16), .ADDR_W(22)) dut (
        .clk(clk), .reset(reset), .clear(clear), .in_addr(in_addr), .in_data(in_data),
        .in_write(in_write), .clkref(clkref), .sdram_busy(sdram_busy),
        .mem_addr(mem_addr), .mem_data(mem_data), .mem_we(mem_we), .full(full),
        .idle(idle), .overflow(overflow), .bytes_done(bytes_done), .checksum(checksum)
    );

    always #5 clk = ~clk;
    always @(posedge clk) clkref <= ~clkref;

    // strobe log: address/data at rise, clkref sampled at the rising edge, width
    logic [21:0] a_q[$];
    logic [7:0]  d_q[$];
    logic        ck_q[$];
    int          w_q[$];
    int          w = 0;
    logic        we_prev = 1'b0, ck_prev = 1'b0;

    always @(negedge clk) begin
        if (mem_we && !we_prev) begin
            a_q.push_back(mem_addr);
            d_q.push_back(mem_data);
            ck_q.push_back(ck_prev);
            w = 1;
        end else if (mem_we) begin
            w = w + 1;
        end else if (we_prev) begin
            w_q.push_back(w);
        end
        we_prev = mem_we;
        ck_prev = clkref;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic push(input logic [21:0] a, input logic [7:0] d);
        in_addr = a; in_data = d; in_write = 1'b1;
        @(posedge clk); #1;
        in_write = 1'b0;
    endtask

    task automatic do_clear();
        clear = 1'b1;
        @(posedge clk); #1;
        clear = 1'b0;
    endtask

    task automatic flush();
        a_q.delete(); d_q.delete(); ck_q.delete(); w_q.delete();
    endtask

    task automatic wait_idle(input int maxc, input string tag);
        int n = 0;
        while (!(idle && !mem_we) && n < maxc) begin
            @(posedge clk); #1;
            n++;
        end
        chk(tag, {31'b0, idle}, 32'd1);
        @(negedge clk); #1;
    endtask

    task automatic wait_we(input int maxc, input string tag);
        int n = 0;
        while (!mem_we && n < maxc) begin
            @(posedge clk); #1;
            n++;
        end
        chk(tag, {31'b0, mem_we}, 32'd1);
    endtask

    task automatic wait_clkref();
        int n = 0;
        while (clkref !== 1'b1 && n < 4) begin
            @(posedge clk); #1;
            n++;
        end
    endtask

    logic [7:0] t1d [3] = '{8'hA5, 8'h5A, 8'hFF};
    logic [15:0] t1_sum;

    initial begin
`ifdef LOADER_SDRAM_WRITER_CHECKSUM_EN
        t1_sum = 16'h01FE;
`else
        t1_sum = 16'h0000;
`endif
        repeat (3) @(posedge clk);
        #1;
        chk("rst_mem_addr", 32'(mem_addr), 32'h0);
        chk("rst_mem_we",   {31'b0, mem_we}, 32'd0);
        chk("rst_full",     {31'b0, full}, 32'd0);
        chk("rst_idle",     {31'b0, idle}, 32'd1);
        chk("rst_overflow", {31'b0, overflow}, 32'd0);
        chk("rst_bytes",    32'(bytes_done), 32'd0);
        chk("rst_checksum", 32'(checksum), 32'd0);
        reset = 1'b0;
        @(posedge clk); #1;
        flush();

        // 1: three bytes in order, 2-cycle strobes on clkref
        push(22'h000000, 8'hA5);
        push(22'h000001, 8'h5A);
        push(22'h000002, 8'hFF);
        wait_idle(60, "t1_idle_timeout");
        chk("t1_count", a_q.size(), 32'd3);
        for (int i = 0; i < 3; i++) begin
            chk($sformatf("t1_addr%0d", i), 32'(a_q[i]), i);
            chk($sformatf("t1_data%0d", i), 32'(d_q[i]), 32'(t1d[i]));
            chk($sformatf("t1_clkref%0d", i), {31'b0, ck_q[i]}, 32'd1);
            chk($sformatf("t1_width%0d", i), w_q[i], 32'd2);
        end
        chk("t1_bytes", 32'(bytes_done), 32'd3);
        chk("t1_checksum", 32'(checksum), 32'(t1_sum));

        // 2: busy backpressure, full, sticky overflow, ordered drain
        do_clear(); flush();
        sdram_busy = 1'b1;
        for (int i = 0; i < 16; i++) push(22'(32'h100 + i), 8'(16 + i));
        chk("t2_full", {31'b0, full}, 32'd1);
        chk("t2_no_we", a_q.size(), 32'd0);
        chk("t2_ovf_pre", {31'b0, overflow}, 32'd0);
        push(22'h3FFFFF, 8'hEE);
        chk("t2_ovf", {31'b0, overflow}, 32'd1);
        sdram_busy = 1'b0;
        wait_idle(200, "t2_idle_timeout");
        chk("t2_count", a_q.size(), 32'd16);
        for (int i = 0; i < 16; i++) begin
            chk($sformatf("t2_addr%0d", i), 32'(a_q[i]), 32'h100 + i);
            chk($sformatf("t2_data%0d", i), 32'(d_q[i]), 32'(16 + i));
        end
        chk("t2_bytes", 32'(bytes_done), 32'd16);
        chk("t2_ovf_sticky", {31'b0, overflow}, 32'd1);
        chk("t2_not_full", {31'b0, full}, 32'd0);

        // 3: busy raised during WE0 does not shorten the strobe
        do_clear(); flush();
        push(22'h000055, 8'h11);
        push(22'h000056, 8'h22);
        wait_we(20, "t3_we_timeout");
        sdram_busy = 1'b1;
        repeat (10) @(posedge clk);
        #1;
        chk("t3_held", a_q.size(), 32'd1);
        chk("t3_width0", w_q[0], 32'd2);
        sdram_busy = 1'b0;
        wait_idle(40, "t3_idle_timeout");
        chk("t3_count", a_q.size(), 32'd2);
        chk("t3_data1", 32'(d_q[1]), 32'h22);
        chk("t3_clkref1", {31'b0, ck_q[1]}, 32'd1);
        chk("t3_width1", w_q[1], 32'd2);

        // 4: push and pop on the same edge with five queued
        do_clear(); flush();
        sdram_busy = 1'b1;
        for (int i = 0; i < 5; i++) push(22'(32'h200 + i), 8'(8'h30 + i));
        wait_clkref();
        sdram_busy = 1'b0;
        push(22'h000205, 8'h35);
        sdram_busy = 1'b1;
        chk("t4_popped", {31'b0, mem_we}, 32'd1);
        for (int i = 6; i < 16; i++) push(22'(32'h200 + i), 8'(8'h30 + i));
        chk("t4_not_full15", {31'b0, full}, 32'd0);
        push(22'h000210, 8'h40);
        chk("t4_full16", {31'b0, full}, 32'd1);
        push(22'h3F0000, 8'hEE);
        chk("t4_ovf", {31'b0, overflow}, 32'd1);
        sdram_busy = 1'b0;
        wait_idle(200, "t4_idle_timeout");
        chk("t4_count", a_q.size(), 32'd17);
        for (int i = 0; i < 17; i++) begin
            chk($sformatf("t4_addr%0d", i), 32'(a_q[i]), 32'h200 + i);
            chk($sformatf("t4_data%0d", i), 32'(d_q[i]), 32'h30 + i);
        end
        chk("t4_bytes", 32'(bytes_done), 32'd17);

        // 5: clear during WE1 with four entries still queued
        flush();
        sdram_busy = 1'b1;
        for (int i = 0; i < 5; i++) push(22'(32'h300 + i), 8'(8'h50 + i));
        wait_clkref();
        sdram_busy = 1'b0;
        @(posedge clk); #1;
        chk("t5_we0", {31'b0, mem_we}, 32'd1);
        @(posedge clk); #1;
        clear = 1'b1;
        @(posedge clk); #1;
        clear = 1'b0;
        chk("t5_we_off", {31'b0, mem_we}, 32'd0);
        chk("t5_bytes", 32'(bytes_done), 32'd0);
        chk("t5_ovf", {31'b0, overflow}, 32'd0);
        chk("t5_idle", {31'b0, idle}, 32'd1);
        repeat (20) @(posedge clk);
        #1;
        chk("t5_no_more", a_q.size(), 32'd1);
        chk("t5_bytes_after", 32'(bytes_done), 32'd0);

        // 6: asynchronous reset in the middle of a strobe
        flush();
        push(22'h2AAAAA, 8'h3C);
        wait_we(20, "t6_we_timeout");
        #2;
        reset = 1'b1;
        #1;
        chk("t6_we_async", {31'b0, mem_we}, 32'd0);
        chk("t6_mem_addr", 32'(mem_addr), 32'h0);
        chk("t6_mem_data", 32'(mem_data), 32'h0);
        chk("t6_full", {31'b0, full}, 32'd0);
        chk("t6_idle", {31'b0, idle}, 32'd1);
        chk("t6_ovf", {31'b0, overflow}, 32'd0);
        chk("t6_bytes", 32'(bytes_done), 32'd0);
        chk("t6_checksum", 32'(checksum), 32'd0);
        @(posedge clk); #1;
        reset = 1'b0;

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
